// File: rtl/adc_acq_if.sv
// Signal bundle between the ADC acquisition block, the external SPI ADC and the
// downstream moving-average filter.
interface adc_acq_if #(
  parameter int unsigned NB_SAMPLE = 8
);
  logic                        i_run;
  logic                        i_miso;
  logic                        o_cs_n;
  logic                        o_sclk;
  logic                        o_mosi;
  logic signed [NB_SAMPLE-1:0] o_ch0;
  logic signed [NB_SAMPLE-1:0] o_ch1;
  logic                        o_enable;

  modport master (
    input  i_run,
    input  i_miso,
    output o_cs_n,
    output o_sclk,
    output o_mosi,
    output o_ch0,
    output o_ch1,
    output o_enable
  );

  modport slave (
    output i_run,
    output i_miso,
    input  o_cs_n,
    input  o_sclk,
    input  o_mosi,
    input  o_ch0,
    input  o_ch1,
    input  o_enable
  );
endinterface

// File: rtl/adc_acq.sv
// Frame-paced two-channel SPI ADC reader: converts ch0 then ch1 each frame and
// publishes both as signed samples with a one-clk enable strobe.
module adc_acq #(
  parameter int unsigned NB_SAMPLE = 8,
  parameter int unsigned NB_ADC    = 10,
  parameter int unsigned FRAME_CNT = 1800,
  parameter int unsigned SCLK_HALF = 4
) (
  input logic        clk,
  input logic        rst,
  adc_acq_if.master  bus
);

  localparam int unsigned FW = $clog2(FRAME_CNT);
  localparam int unsigned TW = $clog2(2 * SCLK_HALF);

  localparam logic [FW-1:0] FrmLast  = FW'(FRAME_CNT - 1);
  localparam logic [TW-1:0] HalfLast = TW'(SCLK_HALF - 1);
  localparam logic [TW-1:0] GapLast  = TW'(2 * SCLK_HALF - 1);
  // Result bits arrive on the last NB_ADC of the 16 SCLK periods, minus the final one.
  localparam logic [3:0]    FirstBit = 4'(15 - NB_ADC);

  if (FRAME_CNT <= 66 * SCLK_HALF + 1) begin : g_frame_check
    $error("adc_acq: FRAME_CNT too small for two conversions");
  end
  if (NB_ADC < NB_SAMPLE || NB_ADC > 14 || SCLK_HALF < 1) begin : g_width_check
    $error("adc_acq: unsupported NB_ADC/NB_SAMPLE/SCLK_HALF combination");
  end

  typedef enum logic [2:0] {StIdle, StConv0, StGap, StConv1, StPublish} state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic [NB_ADC-1:0]     sh_q, sh_d;
  logic [NB_SAMPLE-1:0]  s0_q, s0_d;
  logic [NB_SAMPLE-1:0]  ch0_q, ch0_d;
  logic [NB_SAMPLE-1:0]  ch1_q, ch1_d;
  logic                  en_q, en_d;
  logic                  conv_start, conv_end;
  logic [NB_SAMPLE-1:0]  sample_now;

  // Offset binary to two's complement, truncated to the sample width.
  assign sample_now = {~sh_q[NB_ADC-1], sh_q[NB_ADC-2 -: NB_SAMPLE-1]};

  always_comb begin
    state_d    = state_q;
    frm_d      = (frm_q == FrmLast) ? '0 : frm_q + 1'b1;
    tick_d     = tick_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    sh_d       = sh_q;
    s0_d       = s0_q;
    ch0_d      = ch0_q;
    ch1_d      = ch1_q;
    en_d       = 1'b0;
    conv_start = 1'b0;
    conv_end   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frm_q == '0 && bus.i_run) begin
          state_d    = StConv0;
          conv_start = 1'b1;
        end
      end
      StConv0, StConv1: begin
        if (tick_q != HalfLast) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (bit_q >= FirstBit && bit_q <= 4'd14) begin
              sh_d = {sh_q[NB_ADC-2:0], bus.i_miso};
            end
          end else if (bit_q == 4'd15) begin
            conv_end = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            // Command: start, single-ended, channel select, MSB-first.
            case (bit_d)
              4'd1:    mosi_d = 1'b1;
              4'd2:    mosi_d = (state_q == StConv1);
              4'd3:    mosi_d = 1'b1;
              default: mosi_d = 1'b0;
            endcase
          end
        end
      end
      StGap: begin
        if (tick_q == GapLast) begin
          state_d    = StConv1;
          conv_start = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (conv_start) begin
      tick_d = '0;
      bit_d  = '0;
      sclk_d = 1'b0;
      cs_n_d = 1'b0;
      mosi_d = 1'b1;
      sh_d   = '0;
    end

    if (conv_end) begin
      tick_d = '0;
      cs_n_d = 1'b1;
      mosi_d = 1'b0;
      if (state_q == StConv0) begin
        state_d = StGap;
        s0_d    = sample_now;
      end else begin
        state_d = StPublish;
        ch0_d   = s0_q;
        ch1_d   = sample_now;
        en_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      frm_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      sh_q    <= '0;
      s0_q    <= '0;
      ch0_q   <= '0;
      ch1_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      sh_q    <= sh_d;
      s0_q    <= s0_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      en_q    <= en_d;
    end
  end

  assign bus.o_cs_n   = cs_n_q;
  assign bus.o_sclk   = sclk_q;
  assign bus.o_mosi   = mosi_q;
  assign bus.o_ch0    = ch0_q;
  assign bus.o_ch1    = ch1_q;
  assign bus.o_enable = en_q;

endmodule
